// File: rtl/color_scramble_stream.sv
// Colour-channel router with one output register stage and frame-aligned select updates.
// Optional per-channel output inversion is enabled by defining COLOR_SCRAMBLE_INVERT_EN.

module color_scramble_lane #(
  parameter int CH_W  = 4,
  parameter int N_CH  = 3,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0][CH_W-1:0] pix_ch,
  input  logic [SEL_W-1:0]          code,
  output logic [CH_W-1:0]           ch_out
);
  // Codes at or above N_CH never match and fall through to zero.
  always_comb begin
    ch_out = '0;
    for (int c = 0; c < N_CH; c++)
      if (code == SEL_W'(c)) ch_out = pix_ch[c];
  end
endmodule

module color_scramble_stream #(
  parameter int CH_W  = 4,
  parameter int N_CH  = 3,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*SEL_W-1:0] sel_in,
  input  logic                  sel_load,
`ifdef COLOR_SCRAMBLE_INVERT_EN
  input  logic [N_CH-1:0]       inv_in,
`endif
  output logic                  cfg_pending,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [N_CH*CH_W-1:0]  s_pixel,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N_CH*CH_W-1:0]  m_pixel,
  output logic                  m_sof
);
  localparam int PIX_W = N_CH * CH_W;

  if (2**SEL_W < N_CH + 1) begin : g_bad_sel_w
    $error("color_scramble_stream: SEL_W too small to encode N_CH channels plus zero");
  end

  // Internal arrays are indexed by channel number (channel 0 = MSB field).
  typedef logic [N_CH-1:0][SEL_W-1:0] sel_t;

  logic [N_CH-1:0][CH_W-1:0] pix_ch, map_ch;
  sel_t                      sel_in_ch, sel_id, sel_eff;
  sel_t                      sel_act_q, sel_act_d, sel_pend_q, sel_pend_d;
  logic [PIX_W-1:0]          map_pix, m_pixel_q, m_pixel_d;
  logic                      m_valid_q, m_valid_d, m_sof_q, m_sof_d;
  logic                      cfg_pending_q, cfg_pending_d;
  logic                      accept, sof_acc;

`ifdef COLOR_SCRAMBLE_INVERT_EN
  logic [N_CH-1:0] inv_in_ch, inv_eff, inv_act_q, inv_act_d, inv_pend_q, inv_pend_d;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign pix_ch[i]    = s_pixel[(N_CH-i)*CH_W-1 -: CH_W];
    assign sel_in_ch[i] = sel_in[(N_CH-i)*SEL_W-1 -: SEL_W];
    assign sel_id[i]    = SEL_W'(i);

    color_scramble_lane #(.CH_W(CH_W), .N_CH(N_CH), .SEL_W(SEL_W)) u_lane (
      .pix_ch (pix_ch),
      .code   (sel_eff[i]),
      .ch_out (map_ch[i])
    );

`ifdef COLOR_SCRAMBLE_INVERT_EN
    assign inv_in_ch[i] = inv_in[N_CH-1-i];
    assign map_pix[(N_CH-i)*CH_W-1 -: CH_W] = map_ch[i] ^ {CH_W{inv_eff[i]}};
`else
    assign map_pix[(N_CH-i)*CH_W-1 -: CH_W] = map_ch[i];
`endif
  end

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign sof_acc = accept && s_sof;

  always_comb begin
    // A same-cycle load wins over an older pending set at frame start.
    sel_eff = sel_act_q;
    if (sof_acc) begin
      if (sel_load)           sel_eff = sel_in_ch;
      else if (cfg_pending_q) sel_eff = sel_pend_q;
    end
    sel_act_d  = sof_acc ? sel_eff : sel_act_q;
    sel_pend_d = sel_load ? sel_in_ch : sel_pend_q;

    cfg_pending_d = cfg_pending_q;
    if (sel_load) cfg_pending_d = 1'b1;
    if (sof_acc)  cfg_pending_d = 1'b0;

    m_valid_d = m_valid_q;
    m_pixel_d = m_pixel_q;
    m_sof_d   = m_sof_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_pixel_d = map_pix;
      m_sof_d   = s_sof;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

`ifdef COLOR_SCRAMBLE_INVERT_EN
  always_comb begin
    inv_eff = inv_act_q;
    if (sof_acc) begin
      if (sel_load)           inv_eff = inv_in_ch;
      else if (cfg_pending_q) inv_eff = inv_pend_q;
    end
    inv_act_d  = sof_acc ? inv_eff : inv_act_q;
    inv_pend_d = sel_load ? inv_in_ch : inv_pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_act_q  <= '0;
      inv_pend_q <= '0;
    end else begin
      inv_act_q  <= inv_act_d;
      inv_pend_q <= inv_pend_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_act_q     <= sel_id;
      sel_pend_q    <= sel_id;
      cfg_pending_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_pixel_q     <= '0;
      m_sof_q       <= 1'b0;
    end else begin
      sel_act_q     <= sel_act_d;
      sel_pend_q    <= sel_pend_d;
      cfg_pending_q <= cfg_pending_d;
      m_valid_q     <= m_valid_d;
      m_pixel_q     <= m_pixel_d;
      m_sof_q       <= m_sof_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_pixel     = m_pixel_q;
  assign m_sof       = m_sof_q;
  assign cfg_pending = cfg_pending_q;
endmodule

// File: doc/color_scramble_stream.md
Name: color_scramble_stream

Overview:
Parametrised, pipelined colour-channel router for the pixel stream. Each output channel takes any input channel, or zero, as chosen by a per-channel select code. The block has a valid/ready handshake with one register stage. New select settings are held back and take effect only at a start-of-frame beat, so a frame never changes mapping partway through. It sits between the pixel source (frame buffer read-out) and the display/VGA formatter.

Parameters:
CH_W, 4, bits per colour channel
N_CH, 3, number of colour channels; channel 0 is the most-significant field (red)
SEL_W, 2, bits per select code; must satisfy 2**SEL_W >= N_CH+1 (elaboration error otherwise)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sel_in  in  N_CH*SEL_W  select codes; field i at [(N_CH-i)*SEL_W-1 -: SEL_W]
sel_load  in  1  capture sel_in into pending register (single-cycle strobe)
cfg_pending  out  1  high while a captured select set is waiting for the next frame start
s_valid  in  1  input beat valid
s_ready  out  1  block can accept a beat
s_pixel  in  N_CH*CH_W  input pixel; channel i at [(N_CH-i)*CH_W-1 -: CH_W]
s_sof  in  1  input beat is first pixel of a frame
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts the beat
m_pixel  out  N_CH*CH_W  scrambled pixel, same field layout as s_pixel
m_sof  out  1  start-of-frame, aligned with m_pixel

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_pixel=0, m_sof=0, cfg_pending=0. Active and pending selects = identity (field i = i).
- Mapping per output channel i with code c: c < N_CH -> input channel c; c >= N_CH -> all zeros.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational, no path from s_valid).
  - Beat accepted when s_valid && s_ready: m_pixel, m_sof and m_valid=1 load next cycle. Latency 1 clock.
  - m_valid && !m_ready: m_pixel and m_sof hold stable and s_ready=0.
  - m_ready && !s_valid while m_valid: m_valid -> 0.
  - Full throughput with m_ready held high.
- Select update:
  - sel_load=1: pending <= sel_in, cfg_pending <= 1. A later sel_load before the frame start overwrites pending; last one wins.
  - On an accepted beat with s_sof=1, effective select = sel_in if sel_load is high this cycle, else pending if cfg_pending, else active. That select maps this beat and is written to active; cfg_pending <= 0.
  - Non-sof beats always use active.
  - sel_load without an accepted sof beat never changes active.
  - sel_load in the same cycle as a stalled sof beat (s_valid && !s_ready): treated as an ordinary load; applied when the sof beat is accepted.
- s_sof on a non-accepted cycle has no effect.
- Reset mid-frame: in-flight beat dropped, selects back to identity.

Optional Feature:
- COLOR_SCRAMBLE_INVERT_EN defined:
  - Adds port inv_in in N_CH, captured into pending with sel_load and promoted to active under the same sof rules as the selects.
  - Output channel i is bitwise inverted when active inv bit i = 1, after selection; a zero-code channel becomes all ones.
  - Reset value of the inv bits is 0.
- Undefined: no inv_in port, no inversion logic; behaviour otherwise identical.

Test Plan:
- Defaults. After reset, s_pixel=12'hABC with s_sof=1 and m_ready=1 -> m_pixel=12'hABC and m_sof=1 one cycle later; cfg_pending=0.
- Swap and zero. sel_load with sel_in=6'b10_01_11 coincident with an accepted sof beat 12'hABC -> m_pixel=12'hCB0 on that beat; following non-sof beat 12'h123 -> 12'h320.
- Deferred update. Mid-frame sel_load with 6'b01_00_10 -> cfg_pending=1. Remaining beats of the frame still use the old mapping. The next sof beat 12'hABC -> 12'hBAC, and cfg_pending drops.
- Back-pressure. m_ready=0 for 3 cycles with s_valid=1 -> s_ready=0 and m_pixel held stable. Release -> no beat lost or duplicated over a 16-beat burst compared with a model.
- Reset. rst asserted mid-frame with m_valid=1 -> m_valid=0 and m_pixel=0 immediately (async). Next frame maps as identity.
- With COLOR_SCRAMBLE_INVERT_EN: inv_in=3'b001 loaded with identity selects at sof, input 12'hABC -> 12'hAB3.
